// File: rtl/nand_chain_stim_checker.sv
// nand_chain_stim_checker
// Sweeps {a,b,c,d} through all 16 patterns into the external NAND chain
// (e=~(a&b), f=~(e&c), g=~(f&d)). Each pattern is held for SETTLE_CYCLES and
// then checked for one cycle. The block compares e/f/g against golden values
// and keeps an error count, a sticky flag and the first failing pattern.
//
// Optional build macro: MISMATCH_HALT_EN. When it is defined, the first
// mismatch ends the sweep. The failing pattern stays on the outputs.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | after reset; waits for start
// SETTLE | pattern driven, chain settling (SETTLE_CYCLES cycles)
// CHECK  | one cycle; e/f/g compared against golden values
// WAIT   | step mode only; holds pattern until a step pulse
// DONE   | sweep finished; results held until the next start
module nand_chain_stim_checker #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  input  logic       e_in,
  input  logic       f_in,
  input  logic       g_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] pattern_idx,
  output logic       busy,
  output logic       done,
  output logic       err_flag,
  output logic [4:0] err_count,
  output logic [3:0] first_err_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [4:0] ERR_MAX     = 5'd16;
  localparam logic [3:0] LAST_IDX    = 4'd15;

  state_t     state;
  logic [3:0] pattern_q;
  logic [3:0] settle_cnt;
  logic       step_latched;
  logic       busy_q;
  logic       done_q;
  logic       err_flag_q;
  logic [4:0] err_count_q;
  logic [3:0] first_err_q;

  logic       ge;
  logic       gf;
  logic       gg;
  logic       mismatch;

  // The stimulus bits are just the pattern register fanned out, so
  // {a,b,c,d} can never disagree with pattern_idx.
  assign a             = pattern_q[3];
  assign b             = pattern_q[2];
  assign c             = pattern_q[1];
  assign d             = pattern_q[0];
  assign pattern_idx   = pattern_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_flag      = err_flag_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

  // Golden NAND chain response for the pattern currently being driven.
  always_comb begin
    ge       = ~(pattern_q[3] & pattern_q[2]);
    gf       = ~(ge & pattern_q[1]);
    gg       = ~(gf & pattern_q[0]);
    mismatch = ({e_in, f_in, g_in} != {ge, gf, gg});
  end

  // Sweep sequencer: state, stimulus, settle timer and error bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      pattern_q    <= 4'd0;
      settle_cnt   <= 4'd0;
      step_latched <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_flag_q   <= 1'b0;
      err_count_q  <= 5'd0;
      first_err_q  <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_SETTLE;
            pattern_q    <= 4'd0;
            settle_cnt   <= 4'd0;
            step_latched <= step_mode;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            err_flag_q   <= 1'b0;
            err_count_q  <= 5'd0;
            first_err_q  <= 4'd0;
          end
        end

        S_SETTLE: begin
          settle_cnt <= settle_cnt + 4'd1;
          if (settle_cnt == SETTLE_LAST) begin
            state <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
              err_count_q <= err_count_q + 5'd1;
            end
            err_flag_q <= 1'b1;
            // The sticky flag is still clear on the first mismatch of a sweep.
            if (!err_flag_q) begin
              first_err_q <= pattern_q;
            end
          end
`ifdef MISMATCH_HALT_EN
          if (mismatch || (pattern_q == LAST_IDX)) begin
`else
          if (pattern_q == LAST_IDX) begin
`endif
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (step_latched) begin
            state <= S_WAIT;
          end else begin
            state      <= S_SETTLE;
            pattern_q  <= pattern_q + 4'd1;
            settle_cnt <= 4'd0;
          end
        end

        S_WAIT: begin
          if (step) begin
            state      <= S_SETTLE;
            pattern_q  <= pattern_q + 4'd1;
            settle_cnt <= 4'd0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
